vm_controller: RTL and testbench

- Core vending FSM fed directly by the debouncer stage: consumes single-cycle, clock-synchronous pulses for coin insertion, purchase request and cancel.
- Accumulates credit, authorises a vend, holds the dispense strobe for a fixed time, and returns change or a refund.
- Runs on the divided system clock (nominal 2 Hz); all outputs are registered.

---
 rtl/vm_pkg.sv | 34 +++
 rtl/vm_controller_if.sv | 36 +++
 rtl/vm_dispense_timer.sv | 36 +++
 rtl/vm_controller.sv | 152 +++++++++++++++
 tb/tb_vm_controller.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/vm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : vm_pkg
// Purpose  : Shared state encoding, default pricing constants, width helpers
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package vm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2
  } vm_state_e;

  localparam int C_DEF_PRICE           = 15;
  localparam int C_DEF_COIN_LO         = 5;
  localparam int C_DEF_COIN_HI         = 10;
  localparam int C_DEF_MAX_CREDIT      = 35;
  localparam int C_DEF_DISPENSE_CYCLES = 4;

  // Bits needed to represent 0..max_value inclusive.
  function automatic int credit_width(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

  // Bits needed for a down-counter loaded with cycles-1.
  function automatic int counter_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

  localparam int C_DEF_CREDIT_W = credit_width(C_DEF_MAX_CREDIT);

endpackage
`default_nettype wire

// File: rtl/vm_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : vm_controller_if
// Purpose  : Pulse inputs and registered status outputs of the vending core
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface vm_controller_if
  import vm_pkg::*;
#(
  parameter int CREDIT_W = C_DEF_CREDIT_W
) ();

  logic                coin_lo;
  logic                coin_hi;
  logic                buy;
  logic                cancel;
  logic [CREDIT_W-1:0] credit;
  logic                dispense;
  logic [CREDIT_W-1:0] change;
  logic                change_valid;
  logic                coin_reject;
  logic                deny;
  logic                busy;

  modport master (
    output coin_lo, coin_hi, buy, cancel,
    input  credit, dispense, change, change_valid, coin_reject, deny, busy
  );

  modport slave (
    input  coin_lo, coin_hi, buy, cancel,
    output credit, dispense, change, change_valid, coin_reject, deny, busy
  );

endinterface
`default_nettype wire

// File: rtl/vm_dispense_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : vm_dispense_timer
// Purpose  : Loadable down-counter that paces how long a dispense is held
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module vm_dispense_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] value_o,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q;

  // Saturates at zero so a stray decrement never wraps into a long hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign value_o = count_q;
  assign done_o  = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/vm_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : vm_controller
// Purpose  : Vending FSM - credit accumulation, vend authorisation, change/refund
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module vm_controller
  import vm_pkg::*;
#(
  parameter int PRICE           = C_DEF_PRICE,
  parameter int COIN_LO         = C_DEF_COIN_LO,
  parameter int COIN_HI         = C_DEF_COIN_HI,
  parameter int MAX_CREDIT      = C_DEF_MAX_CREDIT,
  parameter int CREDIT_W        = C_DEF_CREDIT_W,
  parameter int DISPENSE_CYCLES = C_DEF_DISPENSE_CYCLES
) (
  input  logic           clk,
  input  logic           reset,
  vm_controller_if.slave bus
);

  localparam int TIMER_W = counter_width(DISPENSE_CYCLES);

  localparam logic [CREDIT_W:0]   C_COIN_LO_X = (CREDIT_W + 1)'(COIN_LO);
  localparam logic [CREDIT_W:0]   C_COIN_HI_X = (CREDIT_W + 1)'(COIN_HI);
  localparam logic [CREDIT_W:0]   C_MAX_X     = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] C_PRICE_W   = CREDIT_W'(PRICE);
  localparam logic [TIMER_W-1:0]  C_HOLD_LOAD = TIMER_W'(DISPENSE_CYCLES - 1);

  vm_state_e           state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] change_q;
  logic                change_valid_q;
  logic                coin_reject_q;
  logic                deny_q;
  logic                dispense_q;
  logic                busy_q;

  logic [CREDIT_W:0]   sum_lo;
  logic [CREDIT_W:0]   sum_hi;
  logic                lo_fits;
  logic                hi_fits;
  logic                can_vend;
  logic                in_vend;
  logic                vend_start;
  logic                any_coin;
  logic                timer_done;
  logic [TIMER_W-1:0]  timer_value_unused;

  // Sums carry one extra bit so an over-ceiling coin cannot wrap and look valid.
  assign sum_lo     = {1'b0, credit_q} + C_COIN_LO_X;
  assign sum_hi     = {1'b0, credit_q} + C_COIN_HI_X;
  assign lo_fits    = (sum_lo <= C_MAX_X);
  assign hi_fits    = (sum_hi <= C_MAX_X);
  assign can_vend   = (credit_q >= C_PRICE_W);
  assign in_vend    = (state_q == VEND);
  assign any_coin   = bus.coin_lo | bus.coin_hi;
  assign vend_start = !in_vend && !bus.cancel && bus.buy && can_vend;

  vm_dispense_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .load_i       (vend_start),
    .load_value_i (C_HOLD_LOAD),
    .dec_i        (in_vend),
    .value_o      (timer_value_unused),
    .done_o       (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      change_q       <= '0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      deny_q         <= 1'b0;
      dispense_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      deny_q         <= 1'b0;

      case (state_q)
        IDLE, CREDIT: begin
          if (bus.cancel) begin
            coin_reject_q <= any_coin;
            if (credit_q != '0) begin
              change_q       <= credit_q;
              change_valid_q <= 1'b1;
              credit_q       <= '0;
              state_q        <= IDLE;
            end
          end else if (bus.buy) begin
            coin_reject_q <= any_coin;
            if (can_vend) begin
              change_q       <= credit_q - C_PRICE_W;
              change_valid_q <= 1'b1;
              credit_q       <= '0;
              dispense_q     <= 1'b1;
              busy_q         <= 1'b1;
              state_q        <= VEND;
            end else begin
              deny_q <= 1'b1;
            end
          end else if (bus.coin_hi) begin
            coin_reject_q <= bus.coin_lo || !hi_fits;
            if (hi_fits) begin
              credit_q <= sum_hi[CREDIT_W-1:0];
              state_q  <= CREDIT;
            end
          end else if (bus.coin_lo) begin
            coin_reject_q <= !lo_fits;
            if (lo_fits) begin
              credit_q <= sum_lo[CREDIT_W-1:0];
              state_q  <= CREDIT;
            end
          end
        end

        VEND: begin
          coin_reject_q <= any_coin;
          if (timer_done) begin
            dispense_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end

        default: begin
          state_q    <= IDLE;
          credit_q   <= '0;
          dispense_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.credit       = credit_q;
  assign bus.dispense     = dispense_q;
  assign bus.change       = change_q;
  assign bus.change_valid = change_valid_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.deny         = deny_q;
  assign bus.busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_vm_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_vm_controller
// Purpose  : Directed plan plus randomized pulses against a cycle-level model
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_vm_controller;

  localparam int PRICE      = 15;
  localparam int COIN_LO    = 5;
  localparam int COIN_HI    = 10;
  localparam int MAX_CREDIT = 35;
  localparam int CREDIT_W   = 6;
  localparam int DISP       = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Model state: credit in units, last change, dispense cycles still to show.
  int   m_credit;
  int   m_change;
  int   m_left;
  bit   m_cv;
  bit   m_rej;
  bit   m_deny;

  vm_controller_if #(.CREDIT_W(CREDIT_W)) bus ();

  vm_controller #(
    .PRICE           (PRICE),
    .COIN_LO         (COIN_LO),
    .COIN_HI         (COIN_HI),
    .MAX_CREDIT      (MAX_CREDIT),
    .CREDIT_W        (CREDIT_W),
    .DISPENSE_CYCLES (DISP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    if (obs !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_step(input bit lo, input bit hi, input bit b,
                                     input bit c, input bit r);
    if (r) begin
      m_credit = 0; m_change = 0; m_left = 0;
      m_cv = 0; m_rej = 0; m_deny = 0;
      return;
    end
    m_cv = 0; m_rej = 0; m_deny = 0;
    if (m_left > 0) begin
      m_rej  = lo | hi;
      m_left = m_left - 1;
    end else if (c) begin
      m_rej = lo | hi;
      if (m_credit > 0) begin
        m_change = m_credit; m_cv = 1; m_credit = 0;
      end
    end else if (b) begin
      m_rej = lo | hi;
      if (m_credit >= PRICE) begin
        m_change = m_credit - PRICE; m_cv = 1; m_credit = 0; m_left = DISP;
      end else begin
        m_deny = 1;
      end
    end else if (hi) begin
      if (m_credit + COIN_HI <= MAX_CREDIT) m_credit += COIN_HI;
      else m_rej = 1;
      if (lo) m_rej = 1;
    end else if (lo) begin
      if (m_credit + COIN_LO <= MAX_CREDIT) m_credit += COIN_LO;
      else m_rej = 1;
    end
  endfunction

  task automatic check_all();
    check($sformatf("credit@%0d", cyc),       32'(bus.credit),       m_credit);
    check($sformatf("dispense@%0d", cyc),     32'(bus.dispense),     int'(m_left > 0));
    check($sformatf("busy@%0d", cyc),         32'(bus.busy),         int'(m_left > 0));
    check($sformatf("change@%0d", cyc),       32'(bus.change),       m_change);
    check($sformatf("change_valid@%0d", cyc), 32'(bus.change_valid), int'(m_cv));
    check($sformatf("coin_reject@%0d", cyc),  32'(bus.coin_reject),  int'(m_rej));
    check($sformatf("deny@%0d", cyc),         32'(bus.deny),         int'(m_deny));
  endtask

  task automatic cycle(input bit lo, input bit hi, input bit b, input bit c, input bit r);
    bus.coin_lo = lo;
    bus.coin_hi = hi;
    bus.buy     = b;
    bus.cancel  = c;
    reset       = r;
    @(posedge clk);
    model_step(lo, hi, b, c, r);
    #1;
    check_all();
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.coin_lo = 1'b0;
    bus.coin_hi = 1'b0;
    bus.buy     = 1'b0;
    bus.cancel  = 1'b0;
    reset       = 1'b1;

    cycle(0, 0, 0, 0, 1);
    cycle(1, 1, 1, 1, 1);
    check("reset_credit", 32'(bus.credit), 0);
    check("reset_dispense", 32'(bus.dispense), 0);

    // Exact payment.
    cycle(0, 1, 0, 0, 0);
    check("exact_c10", 32'(bus.credit), 10);
    cycle(1, 0, 0, 0, 0);
    check("exact_c15", 32'(bus.credit), 15);
    cycle(0, 0, 1, 0, 0);
    check("exact_disp", 32'(bus.dispense), 1);
    check("exact_cv", 32'(bus.change_valid), 1);
    check("exact_chg", 32'(bus.change), 0);
    idle(3);
    check("exact_disp_last", 32'(bus.dispense), 1);
    idle(1);
    check("exact_disp_end", 32'(bus.dispense), 0);

    // Overpay with change.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    check("over_c20", 32'(bus.credit), 20);
    cycle(0, 0, 1, 0, 0);
    check("over_chg", 32'(bus.change), 5);
    idle(4);

    // Ceiling.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    check("ceil_c30", 32'(bus.credit), 30);
    cycle(1, 0, 0, 0, 0);
    check("ceil_c35", 32'(bus.credit), 35);
    cycle(0, 1, 0, 0, 0);
    check("ceil_rej", 32'(bus.coin_reject), 1);
    check("ceil_hold", 32'(bus.credit), 35);
    cycle(0, 0, 0, 1, 0);
    check("ceil_refund", 32'(bus.change), 35);

    // Deny and refund.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    check("deny_pulse", 32'(bus.deny), 1);
    check("deny_credit", 32'(bus.credit), 5);
    cycle(0, 0, 0, 1, 0);
    check("refund_chg", 32'(bus.change), 5);
    check("refund_cv", 32'(bus.change_valid), 1);
    cycle(0, 0, 0, 1, 0);
    check("refund_again_cv", 32'(bus.change_valid), 0);

    // Simultaneous events and busy.
    cycle(1, 1, 0, 0, 0);
    check("simul_c10", 32'(bus.credit), 10);
    check("simul_rej", 32'(bus.coin_reject), 1);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 1, 0);
    check("buycan_chg", 32'(bus.change), 20);
    check("buycan_disp", 32'(bus.dispense), 0);
    cycle(0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("vend_rej", 32'(bus.coin_reject), 1);
    check("vend_credit", 32'(bus.credit), 0);
    check("vend_busy", 32'(bus.busy), 1);
    idle(3);
    check("vend_busy_end", 32'(bus.busy), 0);

    // Reset mid-vend, asserted in the second dispense cycle.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    idle(1);
    check("midvend_disp2", 32'(bus.dispense), 1);
    cycle(0, 0, 0, 0, 1);
    check("midvend_disp", 32'(bus.dispense), 0);
    check("midvend_busy", 32'(bus.busy), 0);
    check("midvend_chg", 32'(bus.change), 0);
    check("midvend_cv", 32'(bus.change_valid), 0);
    idle(2);

    // Randomized pulse traffic with rare resets.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(3) == 0, $urandom_range(3) == 0,
            $urandom_range(5) == 0, $urandom_range(11) == 0,
            $urandom_range(299) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
